// File: rtl/mem_pkg.sv
// Package: mem_pkg
// Shared encodings for the data-memory load/store sequencer:
//   - OP_*     : request op codes presented on req_op
//   - INCH_*   : dmem store-width select (dmem_inchoice)
//   - OUTCH_*  : dmem load-type select (dmem_outchoice)
//   - mem_state_e : sequencer FSM states
//   - access_misaligned() : alignment rule shared by decode and anyone else who needs it
package mem_pkg;

    localparam logic [3:0] OP_LW  = 4'd0;
    localparam logic [3:0] OP_LH  = 4'd1;
    localparam logic [3:0] OP_LHU = 4'd2;
    localparam logic [3:0] OP_LB  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SB  = 4'd10;

    localparam logic [1:0] INCH_WORD = 2'b00;
    localparam logic [1:0] INCH_HALF = 2'b01;
    localparam logic [1:0] INCH_BYTE = 2'b10;

    localparam logic [2:0] OUTCH_LW  = 3'b000;
    localparam logic [2:0] OUTCH_LH  = 3'b001;
    localparam logic [2:0] OUTCH_LHU = 3'b010;
    localparam logic [2:0] OUTCH_LB  = 3'b011;
    localparam logic [2:0] OUTCH_LBU = 3'b100;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StWait   = 2'd2,
        StDone   = 2'd3
    } mem_state_e;

    // Width is expressed in the INCH_* encoding so loads and stores share one rule.
    function automatic logic access_misaligned(input logic [1:0] width,
                                               input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (width)
            INCH_WORD: mis = (addr_lo != 2'b00);
            INCH_HALF: mis = addr_lo[0];
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_op_decode.sv
// Module: mem_op_decode
// Purely combinational decode of a memory op code into dmem controls.
// Ports:
//   op          in  4  request op code (OP_* in mem_pkg)
//   addr_lo     in  2  low byte-address bits, for the alignment check
//   is_load     out 1  op is LW/LH/LHU/LB/LBU
//   is_store    out 1  op is SW/SH/SB
//   inchoice    out 2  access width in INCH_* encoding (dmem store width)
//   outchoice   out 3  dmem load type (OUTCH_*)
//   misaligned  out 1  valid op whose address breaks its natural alignment
module mem_op_decode
    import mem_pkg::*;
(
    input  logic [3:0] op,
    input  logic [1:0] addr_lo,
    output logic       is_load,
    output logic       is_store,
    output logic [1:0] inchoice,
    output logic [2:0] outchoice,
    output logic       misaligned
);

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        inchoice  = INCH_WORD;
        outchoice = OUTCH_LW;
        case (op)
            OP_LW: begin
                is_load   = 1'b1;
                outchoice = OUTCH_LW;
            end
            OP_LH: begin
                is_load   = 1'b1;
                inchoice  = INCH_HALF;
                outchoice = OUTCH_LH;
            end
            OP_LHU: begin
                is_load   = 1'b1;
                inchoice  = INCH_HALF;
                outchoice = OUTCH_LHU;
            end
            OP_LB: begin
                is_load   = 1'b1;
                inchoice  = INCH_BYTE;
                outchoice = OUTCH_LB;
            end
            OP_LBU: begin
                is_load   = 1'b1;
                inchoice  = INCH_BYTE;
                outchoice = OUTCH_LBU;
            end
            OP_SW: begin
                is_store = 1'b1;
            end
            OP_SH: begin
                is_store = 1'b1;
                inchoice = INCH_HALF;
            end
            OP_SB: begin
                is_store = 1'b1;
                inchoice = INCH_BYTE;
            end
            default: begin
                is_load  = 1'b0;
                is_store = 1'b0;
            end
        endcase
        // Unused op codes are no-ops and never trap.
        misaligned = (is_load | is_store) & access_misaligned(inchoice, addr_lo);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Module: mem_access_ctrl
// Load/store sequencer sitting directly in front of the data memory. Accepts one op
// at a time from the MEM stage, drives the registered dmem controls, absorbs the
// dmem's one-cycle registered read latency and reports completion with a done pulse.
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned word/half ops are trapped at acceptance (IDLE->DONE, fault=1)
//   undefined : no alignment check, fault is always 0
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   req_valid        request strobe, sampled only in IDLE
//   req_op           op code (OP_* in mem_pkg)
//   req_addr         byte address
//   req_wdata        store data, right-justified
//   busy             request accepted and not yet completed (ACCESS/WAIT)
//   done             one-cycle completion pulse (DONE)
//   rdata            load result, valid while done
//   fault            misalignment flag, valid while done
//   dmem_wen         dmem write enable
//   dmem_inchoice    store width: 00 word, 01 half, 10 byte
//   dmem_outchoice   load type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU
//   dmem_addr        dmem byte address (upper bits zero)
//   dmem_wdata       dmem write data
//   dmem_rdata       dmem data_out, registered inside the dmem
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DMEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              fault,
    output logic              dmem_wen,
    output logic [1:0]        dmem_inchoice,
    output logic [2:0]        dmem_outchoice,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata
);

    mem_state_e state_q, state_d;

    logic              is_load_q, is_load_d;
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              dmem_wen_q, dmem_wen_d;
    logic [1:0]        dmem_inchoice_q, dmem_inchoice_d;
    logic [2:0]        dmem_outchoice_q, dmem_outchoice_d;
    logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;

    logic       dec_is_load;
    logic       dec_is_store;
    logic [1:0] dec_inchoice;
    logic [2:0] dec_outchoice;
    logic       dec_misaligned;
    logic       trap;

    mem_op_decode u_decode (
        .op         (req_op),
        .addr_lo    (req_addr[1:0]),
        .is_load    (dec_is_load),
        .is_store   (dec_is_store),
        .inchoice   (dec_inchoice),
        .outchoice  (dec_outchoice),
        .misaligned (dec_misaligned)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = dec_misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = dec_misaligned;
    assign trap              = 1'b0;
`endif

    // The dmem only decodes the low DMEM_AW address bits.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_W-1:DMEM_AW];

    always_comb begin
        state_d          = state_q;
        is_load_d        = is_load_q;
        fault_d          = fault_q;
        rdata_d          = rdata_q;
        dmem_wen_d       = 1'b0;
        dmem_inchoice_d  = dmem_inchoice_q;
        dmem_outchoice_d = dmem_outchoice_q;
        dmem_addr_d      = dmem_addr_q;
        dmem_wdata_d     = dmem_wdata_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    is_load_d        = dec_is_load;
                    fault_d          = trap;
                    dmem_inchoice_d  = dec_inchoice;
                    dmem_outchoice_d = dec_outchoice;
                    dmem_addr_d      = {{(ADDR_W-DMEM_AW){1'b0}}, req_addr[DMEM_AW-1:0]};
                    dmem_wdata_d     = req_wdata;
                    if (trap) begin
                        rdata_d = '0;
                        state_d = StDone;
                    end else begin
                        // wen is registered, so it is high exactly for the ACCESS cycle.
                        dmem_wen_d = dec_is_store;
                        state_d    = StAccess;
                        if (!dec_is_load && !dec_is_store) begin
                            rdata_d = '0;
                        end
                    end
                end
            end
            StAccess: begin
                state_d = is_load_q ? StWait : StDone;
            end
            StWait: begin
                // dmem registered the read at the end of ACCESS; data is valid now.
                rdata_d = dmem_rdata;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            is_load_q        <= 1'b0;
            fault_q          <= 1'b0;
            rdata_q          <= '0;
            dmem_wen_q       <= 1'b0;
            dmem_inchoice_q  <= INCH_WORD;
            dmem_outchoice_q <= OUTCH_LW;
            dmem_addr_q      <= '0;
            dmem_wdata_q     <= '0;
        end else begin
            state_q          <= state_d;
            is_load_q        <= is_load_d;
            fault_q          <= fault_d;
            rdata_q          <= rdata_d;
            dmem_wen_q       <= dmem_wen_d;
            dmem_inchoice_q  <= dmem_inchoice_d;
            dmem_outchoice_q <= dmem_outchoice_d;
            dmem_addr_q      <= dmem_addr_d;
            dmem_wdata_q     <= dmem_wdata_d;
        end
    end

    assign busy           = (state_q == StAccess) || (state_q == StWait);
    assign done           = (state_q == StDone);
    assign rdata          = rdata_q;
    assign fault          = fault_q;
    assign dmem_wen       = dmem_wen_q;
    assign dmem_inchoice  = dmem_inchoice_q;
    assign dmem_outchoice = dmem_outchoice_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_wdata     = dmem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl with a behavioural big-endian dmem (registered read,
// extension applied by the dmem from dmem_outchoice). Expected results are queued
// when each op is driven and popped when the op completes.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic        dmem_wen;
    logic [1:0]  dmem_inchoice;
    logic [2:0]  dmem_outchoice;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = 32'h0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .busy           (busy),
        .done           (done),
        .rdata          (rdata),
        .fault          (fault),
        .dmem_wen       (dmem_wen),
        .dmem_inchoice  (dmem_inchoice),
        .dmem_outchoice (dmem_outchoice),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata)
    );

    // Behavioural dmem: 256 bytes, MSB at the lowest address.
    logic [7:0] mem [256] = '{default: 8'h00};
    int         wr_count  = 0;

    function automatic logic [31:0] mem_read(input logic [7:0] a, input logic [2:0] oc);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[a];
        b1 = mem[a + 8'd1];
        b2 = mem[a + 8'd2];
        b3 = mem[a + 8'd3];
        case (oc)
            3'b000:  return {b0, b1, b2, b3};
            3'b001:  return {{16{b0[7]}}, b0, b1};
            3'b010:  return {16'h0000, b0, b1};
            3'b011:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'h000000, b0};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (dmem_wen) begin
            wr_count <= wr_count + 1;
            case (dmem_inchoice)
                2'b00: begin
                    mem[dmem_addr[7:0]]         <= dmem_wdata[31:24];
                    mem[dmem_addr[7:0] + 8'd1]  <= dmem_wdata[23:16];
                    mem[dmem_addr[7:0] + 8'd2]  <= dmem_wdata[15:8];
                    mem[dmem_addr[7:0] + 8'd3]  <= dmem_wdata[7:0];
                end
                2'b01: begin
                    mem[dmem_addr[7:0]]         <= dmem_wdata[15:8];
                    mem[dmem_addr[7:0] + 8'd1]  <= dmem_wdata[7:0];
                end
                2'b10: mem[dmem_addr[7:0]] <= dmem_wdata[7:0];
                default: ;
            endcase
        end
        dmem_rdata <= mem_read(dmem_addr[7:0], dmem_outchoice);
    end

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          wens;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_rdata;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    // Drives one op and observes it for 8 cycles after the accepting edge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic flt, output int lat, output int wens,
                          output int dones, output logic [1:0] inch_seen);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat       = -1;
        wens      = 0;
        dones     = 0;
        rd        = 'x;
        flt       = 1'bx;
        inch_seen = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            if (dmem_wen) begin
                wens++;
                inch_seen = dmem_inchoice;
            end
            if (done) begin
                dones++;
                if (lat < 0) begin
                    lat = k;
                    rd  = rdata;
                    flt = fault;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Runs one op against the head of the scoreboard queue.
    task automatic check_op(input string name, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [1:0] exp_inch);
        logic [31:0] rd;
        logic        flt;
        int          lat, wens, dones;
        logic [1:0]  inch;
        exp_t        e;
        run_op(op, addr, wd, rd, flt, lat, wens, dones, inch);
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== e.lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, e.lat);
        end
        n_checks++;
        if (rd !== e.rdata) begin
            n_fail++;
            $display("FAIL %s rdata: got %h expected %h", name, rd, e.rdata);
        end
        n_checks++;
        if (flt !== e.fault) begin
            n_fail++;
            $display("FAIL %s fault: got %b expected %b", name, flt, e.fault);
        end
        n_checks++;
        if (wens !== e.wens) begin
            n_fail++;
            $display("FAIL %s wen_cycles: got %0d expected %0d", name, wens, e.wens);
        end
        n_checks++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, dones);
        end
        if (e.wens > 0) begin
            n_checks++;
            if (inch !== exp_inch) begin
                n_fail++;
                $display("FAIL %s inchoice: got %b expected %b", name, inch, exp_inch);
            end
        end
    endtask

    task automatic test_reset();
        int wc;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = OP_LW;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, dmem_wen, fault} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got busy/done/wen/fault=%b expected 0000",
                     {busy, done, dmem_wen, fault});
        end
        n_checks++;
        if (rdata !== 32'h0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h expected all 0",
                     rdata, dmem_addr, dmem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Abort an SW while it is in ACCESS.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_SW;
        req_addr  = 32'h40;
        req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || dmem_wen !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_in_access: got busy=%b wen=%b expected 1 1", busy, dmem_wen);
        end
        wc    = wr_count;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, dmem_wen} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_flags: got busy/done/wen=%b expected 000",
                     {busy, done, dmem_wen});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (wr_count !== wc || mem_read(8'h40, 3'b000) !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_no_write: got writes=%0d word=%h expected %0d 00000000",
                     wr_count, mem_read(8'h40, 3'b000), wc);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        last_rdata = 32'h0;
    endtask

    task automatic test_store_load();
        exp_q.push_back('{rdata: last_rdata, fault: 1'b0, lat: 2, wens: 1});
        check_op("sw_10", OP_SW, 32'h10, 32'hDEADBEEF, INCH_WORD);
        exp_q.push_back('{rdata: 32'hDEADBEEF, fault: 1'b0, lat: 3, wens: 0});
        check_op("lw_10", OP_LW, 32'h10, 32'h0, INCH_WORD);
        last_rdata = 32'hDEADBEEF;
    endtask

    task automatic test_byte_ext();
        exp_q.push_back('{rdata: last_rdata, fault: 1'b0, lat: 2, wens: 1});
        check_op("sb_20", OP_SB, 32'h20, 32'h00000080, INCH_BYTE);
        exp_q.push_back('{rdata: 32'hFFFFFF80, fault: 1'b0, lat: 3, wens: 0});
        check_op("lb_20", OP_LB, 32'h20, 32'h0, INCH_WORD);
        exp_q.push_back('{rdata: 32'h00000080, fault: 1'b0, lat: 3, wens: 0});
        check_op("lbu_20", OP_LBU, 32'h20, 32'h0, INCH_WORD);
        last_rdata = 32'h00000080;
    endtask

    task automatic test_half_ext();
        exp_q.push_back('{rdata: last_rdata, fault: 1'b0, lat: 2, wens: 1});
        check_op("sh_22", OP_SH, 32'h22, 32'h00008001, INCH_HALF);
        exp_q.push_back('{rdata: 32'hFFFF8001, fault: 1'b0, lat: 3, wens: 0});
        check_op("lh_22", OP_LH, 32'h22, 32'h0, INCH_WORD);
        exp_q.push_back('{rdata: 32'h00008001, fault: 1'b0, lat: 3, wens: 0});
        check_op("lhu_22", OP_LHU, 32'h22, 32'h0, INCH_WORD);
        last_rdata = 32'h00008001;
    endtask

    task automatic test_back_to_back();
        int wc;
        int dcount;
        wc     = wr_count;
        dcount = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_SW;
        req_addr  = 32'h30;
        req_wdata = 32'h11111111;
        @(posedge clk);
        #1;
        // Second SW held while busy must be dropped.
        req_addr  = 32'h34;
        req_wdata = 32'h22222222;
        for (int k = 1; k <= 8; k++) begin
            if (done) begin
                dcount++;
                req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        n_checks++;
        if (dcount !== 1) begin
            n_fail++;
            $display("FAIL busy_done_pulses: got %0d expected 1", dcount);
        end
        n_checks++;
        if (wr_count - wc !== 1) begin
            n_fail++;
            $display("FAIL busy_writes: got %0d expected 1", wr_count - wc);
        end
        n_checks++;
        if (mem_read(8'h30, 3'b000) !== 32'h11111111 || mem_read(8'h34, 3'b000) !== 32'h0) begin
            n_fail++;
            $display("FAIL busy_mem: got %h %h expected 11111111 00000000",
                     mem_read(8'h30, 3'b000), mem_read(8'h34, 3'b000));
        end
    endtask

    task automatic test_noop();
        exp_q.push_back('{rdata: 32'h0, fault: 1'b0, lat: 2, wens: 0});
        check_op("noop_5", 4'd5, 32'h10, 32'hCAFEF00D, INCH_WORD);
        exp_q.push_back('{rdata: 32'h0, fault: 1'b0, lat: 2, wens: 0});
        check_op("noop_15", 4'd15, 32'h13, 32'h0, INCH_WORD);
        last_rdata = 32'h0;
    endtask

    task automatic test_misalign();
        // Bytes 0x13..0x16 hold EF 00 00 00 from the earlier SW.
        if (TRAP_EN) begin
            exp_q.push_back('{rdata: 32'h0, fault: 1'b1, lat: 1, wens: 0});
        end else begin
            exp_q.push_back('{rdata: 32'hEF000000, fault: 1'b0, lat: 3, wens: 0});
        end
        check_op("lw_13", OP_LW, 32'h13, 32'h0, INCH_WORD);
        // The fault flag clears on the next accepted op.
        exp_q.push_back('{rdata: 32'hDEADBEEF, fault: 1'b0, lat: 3, wens: 0});
        check_op("lw_10_after", OP_LW, 32'h10, 32'h0, INCH_WORD);
    endtask

    initial begin
        last_rdata = 32'h0;
        test_reset();
        test_store_load();
        test_byte_ext();
        test_half_ext();
        test_back_to_back();
        test_noop();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
